camera_capture: RTL and testbench

Pixel assembler sitting directly downstream of the camera-input synchronizer stage. It consumes the already-synchronized camera bus (PCLK, VSYNC, HREF, D[7:0]), detects PCLK rising edges in the `clk` domain, and pairs bytes into RGB565 pixels. Each pixel is emitted with a linear frame-buffer write address. Capture is armed by software or a key, and runs single-shot or continuously.

---
 rtl/camera_pkg.sv | 17 +
 rtl/camera_capture_if.sv | 24 ++
 rtl/cam_edge_detect.sv | 22 ++
 rtl/camera_capture.sv | 151 +++++++++++++++
 tb/tb_camera_capture.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared types and default geometry for the camera capture path, frame buffer
// and VGA reader.
package camera_pkg;

    localparam int unsigned DEF_WIDTH  = 320;
    localparam int unsigned DEF_HEIGHT = 240;
    localparam int unsigned DEF_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    typedef logic [15:0] pixel_t;

endpackage

// File: rtl/camera_capture_if.sv
// Synchronized camera bus in, assembled pixel stream out. The capture block
// is the slave; the camera/sink side is the master.
interface camera_capture_if #(
    parameter int ADDR_W = 17
);
    logic                cam_pclk;
    logic                cam_vsync;
    logic                cam_href;
    logic [7:0]          cam_data;
    // pix_valid is a one-cycle strobe with no backpressure; data/addr hold between strobes.
    logic                pix_valid;
    camera_pkg::pixel_t  pix_data;
    logic [ADDR_W-1:0]   pix_addr;

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  pix_valid, pix_data, pix_addr
    );

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output pix_valid, pix_data, pix_addr
    );
endinterface

// File: rtl/cam_edge_detect.sv
// Per-bit rise/fall detector against a registered copy; the reset value of
// each copy is chosen so no edge can be reported in the first cycle.
module cam_edge_detect #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sig_i,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);
    logic [W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (reset) sig_q <= RST_VAL;
        else       sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;
endmodule

// File: rtl/camera_capture.sv
// Pairs camera bytes into RGB565 pixels and tags each with its linear
// frame-buffer address; armed single-shot or continuous.
module camera_capture
    import camera_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    camera_capture_if.slave  cam,
    input  logic             arm,
    input  logic             continuous,
    output logic             frame_done,
    output logic             busy,
    output cap_state_t       state_o
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0]     X_MAX  = XW'(WIDTH);
    localparam logic [YW-1:0]     Y_MAX  = YW'(HEIGHT);
    localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(WIDTH);

    logic [2:0] rise, fall;
    logic       pclk_rise, vs_fall, vs_rise, href_fall, edge_unused;

    cam_edge_detect #(.W(3), .RST_VAL(3'b001)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  ({cam.cam_href, cam.cam_vsync, cam.cam_pclk}),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign pclk_rise   = rise[0];
    assign vs_rise     = rise[1];
    assign vs_fall     = fall[1];
    assign href_fall   = fall[2];
    assign edge_unused = ^{rise[2], fall[0]};

    cap_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm)     state_d = WAIT_VS;
            WAIT_VS: if (vs_fall) state_d = CAPTURE;
            CAPTURE: if (vs_rise) state_d = continuous ? WAIT_VS : IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        state_o = state_q;
    end

    // base_q is the address of x=0 on the current line, so addr stays y*WIDTH+x without a multiplier.
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
    pixel_t            pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        base_d       = base_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        pix_addr_d   = pix_addr_q;
        frame_done_d = (state_q == CAPTURE) && vs_rise;

        if (state_q == WAIT_VS && vs_fall) begin
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            base_d  = '0;
            phase_d = 1'b0;
        end else if (state_q == CAPTURE && !vs_rise) begin
            if (pclk_rise && cam.cam_href) begin
                if (!phase_q) begin
                    hi_d    = cam.cam_data;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (x_q < X_MAX && y_q < Y_MAX) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = {hi_q, cam.cam_data};
                        pix_addr_d  = addr_q;
                        addr_d      = addr_q + ADDR_W'(1);
                    end
                    if (x_q < X_MAX) x_d = x_q + XW'(1);
                end
            end else if (href_fall) begin
                x_d     = '0;
                phase_d = 1'b0;
                if (y_q < Y_MAX) y_d = y_q + YW'(1);
                // Past the last stored line no pixel is emitted, so the base is left in range.
                if (y_q < Y_LAST) begin
                    base_d = base_q + W_ADDR;
                    addr_d = base_q + W_ADDR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            base_q       <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cam.pix_valid = pix_valid_q;
    assign cam.pix_data  = pix_data_q;
    assign cam.pix_addr  = pix_addr_q;
    assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a small 4x2 frame buffer.
module tb_camera_capture;
    import camera_pkg::*;

    localparam int AW = 3;

    logic       clk = 1'b0;
    logic       reset, arm, continuous, frame_done, busy;
    cap_state_t state;

    camera_capture_if #(.ADDR_W(AW)) cam ();

    camera_capture #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cam        (cam.slave),
        .arm        (arm),
        .continuous (continuous),
        .frame_done (frame_done),
        .busy       (busy),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pix_cnt  = 0;
    int fd_cnt   = 0;
    logic [AW+15:0] exp_q[$];
    logic [7:0]     line_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every emitted pixel must match the head of exp_q.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cam.pix_valid) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pix", {13'd0, cam.pix_addr, cam.pix_data}, 32'hFFFF_FFFF);
            end else begin
                logic [AW+15:0] e;
                e = exp_q.pop_front();
                check("pix_data", 32'(cam.pix_data), 32'(e[15:0]));
                check("pix_addr", 32'(cam.pix_addr), 32'(e[AW+15:16]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic start_frame();
        cam.cam_vsync = 1'b1;
        tick(3);
        cam.cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic end_frame();
        cam.cam_vsync = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam.cam_pclk = 1'b0;
        cam.cam_data = b;
        tick(4);
        cam.cam_pclk = 1'b1;
        tick(4);
    endtask

    task automatic send_line();
        cam.cam_href = 1'b1;
        while (line_q.size() > 0) send_byte(line_q.pop_front());
        cam.cam_pclk = 1'b0;
        cam.cam_href = 1'b0;
        tick(4);
    endtask

    task automatic expect_pix(input int addr, input logic [15:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    initial begin
        int pc0, fd0;
        reset = 1'b1; arm = 1'b0; continuous = 1'b0;
        cam.cam_pclk = 1'b0; cam.cam_vsync = 1'b0; cam.cam_href = 1'b0; cam.cam_data = '0;
        do_reset();

        // Reset state
        check("rst_pix_valid", 32'(cam.pix_valid), 0);
        check("rst_pix_data", 32'(cam.pix_data), 0);
        check("rst_pix_addr", 32'(cam.pix_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(state), 32'(IDLE));

        // Two-pixel line
        fd0 = fd_cnt;
        do_arm();
        check("t1_busy_after_arm", 32'(busy), 1);
        start_frame();
        check("t1_state_capture", 32'(state), 32'(CAPTURE));
        expect_pix(0, 16'hF800);
        expect_pix(1, 16'h07E0);
        line_q = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        send_line();
        check("t1_busy_in_frame", 32'(busy), 1);
        check("t1_pix_hold", 32'(cam.pix_data), 32'h07E0);
        end_frame();
        check("t1_frame_done_cnt", 32'(fd_cnt - fd0), 1);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_drain", 32'(exp_q.size()), 0);

        // Overscan: 3 lines of 6 pixels into a 4x2 buffer
        pc0 = pix_cnt; fd0 = fd_cnt;
        do_arm();
        start_frame();
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 6; p++) begin
                logic [7:0] hi, lo;
                hi = 8'(8'h10 * l + p);
                lo = 8'(8'hA0 + p);
                line_q.push_back(hi);
                line_q.push_back(lo);
                if (l < 2 && p < 4) expect_pix(l * 4 + p, {hi, lo});
            end
            send_line();
        end
        end_frame();
        check("t2_pix_count", 32'(pix_cnt - pc0), 8);
        check("t2_frame_done_cnt", 32'(fd_cnt - fd0), 1);
        check("t2_busy", 32'(busy), 0);
        check("t2_state", 32'(state), 32'(IDLE));
        check("t2_drain", 32'(exp_q.size()), 0);

        // Odd trailing byte discarded; next line starts at address WIDTH
        do_arm();
        start_frame();
        expect_pix(0, 16'h0102);
        expect_pix(1, 16'h0304);
        line_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_line();
        expect_pix(4, 16'h1234);
        line_q = '{8'h12, 8'h34};
        send_line();
        end_frame();
        check("t3_drain", 32'(exp_q.size()), 0);

        // Continuous: two frames, addresses restart
        fd0 = fd_cnt;
        continuous = 1'b1;
        do_arm();
        start_frame();
        expect_pix(0, 16'hAABB);
        line_q = '{8'hAA, 8'hBB};
        send_line();
        end_frame();
        check("t4_state_rearm", 32'(state), 32'(WAIT_VS));
        check("t4_busy_between", 32'(busy), 1);
        cam.cam_vsync = 1'b0;
        tick(3);
        expect_pix(0, 16'hCCDD);
        line_q = '{8'hCC, 8'hDD};
        send_line();
        end_frame();
        check("t4_frame_done_cnt", 32'(fd_cnt - fd0), 2);
        check("t4_busy_after", 32'(busy), 1);
        check("t4_drain", 32'(exp_q.size()), 0);
        continuous = 1'b0;

        // pclk held high through reset, arm and vsync fall
        pc0 = pix_cnt;
        cam.cam_pclk = 1'b1;
        do_reset();
        do_arm();
        start_frame();
        cam.cam_href = 1'b1;
        cam.cam_data = 8'h55;
        tick(8);
        check("t5_no_spurious_pix", 32'(pix_cnt - pc0), 0);
        expect_pix(0, 16'h1122);
        line_q = '{8'h11, 8'h22};
        send_line();
        end_frame();
        check("t5_drain", 32'(exp_q.size()), 0);

        // Reset mid-line after 3 pixels
        fd0 = fd_cnt;
        do_arm();
        start_frame();
        expect_pix(0, 16'h0A0B);
        expect_pix(1, 16'h0C0D);
        expect_pix(2, 16'h0E0F);
        cam.cam_href = 1'b1;
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        send_byte(8'h0D); send_byte(8'h0E); send_byte(8'h0F);
        reset = 1'b1;
        tick(1);
        check("t6_pix_valid", 32'(cam.pix_valid), 0);
        check("t6_pix_data", 32'(cam.pix_data), 0);
        check("t6_pix_addr", 32'(cam.pix_addr), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        cam.cam_href = 1'b0;
        cam.cam_pclk = 1'b0;
        tick(2);
        check("t6_no_frame_done", 32'(fd_cnt - fd0), 0);
        do_arm();
        start_frame();
        expect_pix(0, 16'h9ABC);
        line_q = '{8'h9A, 8'hBC};
        send_line();
        end_frame();
        check("t6_drain", 32'(exp_q.size()), 0);
        check("t6_frame_done_cnt", 32'(fd_cnt - fd0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
